// File: rtl/vme_ram_rdout_if.sv
// Read-port and output-stream bundle for the VME RAM readout sequencer.
// master = sequencer side, slave = RAM read port plus downstream consumer.
interface vme_ram_rdout_if #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 32
);
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;

    modport master (
        output rd_en, rd_addr, dout, dout_valid, dout_last,
        input  rd_data, dout_ready
    );

    modport slave (
        input  rd_en, rd_addr, dout, dout_valid, dout_last,
        output rd_data, dout_ready
    );
endinterface

// File: rtl/vme_ram_rdout.sv
// Read-side sequencer for the per-spill VME RAM: counts writes during LIVE and, on LIVE fall,
// streams the stored entries out in write order over a valid/ready port.
module vme_ram_rdout #(
    parameter int unsigned AW     = 12,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned FDEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          LIVE,
    input  logic          wr_ena,
    input  logic          start_en,
    vme_ram_rdout_if.master bus,
    output logic [AW:0]   n_words,
    output logic          overflow,
    output logic          busy,
    output logic          done,
    output logic          abort_err
);
    localparam int unsigned PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
    localparam int unsigned CW = $clog2(FDEPTH + 1);
    localparam logic [AW:0] MaxCnt = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e        state_q, state_d;
    logic          live_q;
    logic          rise, fall, abort;
    logic [AW:0]   wcnt_q, wcnt_d;
    logic [AW-1:0] last_wa_q, last_wa_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] ra_q, ra_d;
    logic [AW:0]   rem_q, rem_d;
    logic [AW-1:0] first_addr;
    logic [AW:0]   total;
    logic          abort_err_q;

    logic [RD_LAT-1:0] pipe_v_q, pipe_l_q;
    logic [DW:0]       mem_q [FDEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     cnt_q;
    logic [CW:0]       occ;
    logic              credit, issue, push, pop, fifo_valid;

    assign rise  = LIVE & ~live_q;
    assign fall  = ~LIVE & live_q;
    assign busy  = (state_q == StRead) || (state_q == StDrain);
    assign done  = (state_q == StDone);
    assign abort = rise & busy;

    // Only strobes seen while LIVE is high belong to the spill; a rise restarts counting at once.
    always_comb begin
        wcnt_d    = wcnt_q;
        last_wa_d = last_wa_q;
        ovf_d     = ovf_q;
        if (rise) begin
            wcnt_d    = '0;
            last_wa_d = '0;
            ovf_d     = 1'b0;
        end
        if (LIVE && wr_ena) begin
            last_wa_d = last_wa_d + 1'b1;
            if (wcnt_d != MaxCnt) wcnt_d = wcnt_d + 1'b1;
            if (wcnt_d == MaxCnt) ovf_d = 1'b1;
        end
    end

    // Entries live at 1..N; after a wrap the oldest entry sits just past the last write.
    assign first_addr = ovf_q ? last_wa_q + 1'b1 : AW'(1);
    assign total      = ovf_q ? MaxCnt : wcnt_q;

    // Words already requested but not yet taken downstream must fit in the FIFO.
    assign occ    = {1'b0, cnt_q} + (CW + 1)'($countones(pipe_v_q));
    assign credit = occ < (CW + 1)'(FDEPTH);
    assign issue  = (state_q == StRead) && credit && !reset && !abort;

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rem_d   = rem_q;
        unique case (state_q)
            StIdle: begin
                if (fall && start_en) begin
                    if (wcnt_q == '0) begin
                        state_d = StDone;
                    end else begin
                        ra_d    = first_addr;
                        rem_d   = total;
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                if (issue) begin
                    ra_d  = ra_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == (AW + 1)'(1)) state_d = StDrain;
                end
            end
            StDrain: begin
                if (pipe_v_q == '0 && cnt_q == '0) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            live_q      <= 1'b0;
            wcnt_q      <= '0;
            last_wa_q   <= '0;
            ovf_q       <= 1'b0;
            ra_q        <= '0;
            rem_q       <= '0;
            abort_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            live_q    <= LIVE;
            wcnt_q    <= wcnt_d;
            last_wa_q <= last_wa_d;
            ovf_q     <= ovf_d;
            ra_q      <= ra_d;
            rem_q     <= rem_d;
            if (abort) abort_err_q <= 1'b1;
        end
    end

    assign fifo_valid = (cnt_q != '0);
    assign push       = pipe_v_q[RD_LAT-1];
    assign pop        = fifo_valid && bus.dout_ready;

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            pipe_v_q <= '0;
            pipe_l_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
        end else begin
            pipe_v_q <= (pipe_v_q << 1) | RD_LAT'(issue);
            pipe_l_q <= (pipe_l_q << 1) | RD_LAT'(issue && rem_q == (AW + 1)'(1));
            if (push) wptr_q <= (wptr_q == PW'(FDEPTH - 1)) ? '0 : wptr_q + 1'b1;
            if (pop)  rptr_q <= (rptr_q == PW'(FDEPTH - 1)) ? '0 : rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {pipe_l_q[RD_LAT-1], bus.rd_data};
    end

    assign bus.rd_en      = issue;
    assign bus.rd_addr    = ra_q;
    assign bus.dout_valid = fifo_valid;
    assign bus.dout       = fifo_valid ? mem_q[rptr_q][DW-1:0] : '0;
    assign bus.dout_last  = fifo_valid & mem_q[rptr_q][DW];

    assign n_words   = wcnt_q;
    assign overflow  = ovf_q;
    assign abort_err = abort_err_q;
endmodule
